// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: PC/controller inputs, instruction-memory read port and decoder handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface instruction_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  pc;
    logic               fetch_en;
    logic               flush;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_valid;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         opcode;
    logic               instr_valid;
    logic               instr_ready;
    logic               inc_pc;
    logic               fetch_err;

    modport master (
        input  pc, fetch_en, flush, mem_rdata, mem_valid, instr_ready,
        output mem_addr, mem_rd, instr, opcode, instr_valid, inc_pc, fetch_err
    );

    modport slave (
        output pc, fetch_en, flush, mem_rdata, mem_valid, instr_ready,
        input  mem_addr, mem_rd, instr, opcode, instr_valid, inc_pc, fetch_err
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: reads instruction memory at the current PC, holds the word for the decoder,
// pulses inc_pc once per completed fetch and flags reads that never answer.
module instruction_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_fetch_if.master  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

    logic [1:0]         state;
    logic [3:0]         timer;
    logic               hold_off;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic               mem_rd_r;
    logic [INSTR_W-1:0] instr_r;
    logic               instr_valid_r;
    logic               inc_pc_r;
    logic               fetch_err_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            timer         <= '0;
            hold_off      <= 1'b0;
            mem_addr_r    <= '0;
            mem_rd_r      <= 1'b0;
            instr_r       <= '0;
            instr_valid_r <= 1'b0;
            inc_pc_r      <= 1'b0;
            fetch_err_r   <= 1'b0;
        end else begin
            inc_pc_r <= 1'b0;
            hold_off <= 1'b0;
            // A branch load lands on the PC mid-cycle, so the cycle after a flush never samples pc.
            if (bus.flush) begin
                state         <= ST_IDLE;
                mem_rd_r      <= 1'b0;
                instr_valid_r <= 1'b0;
                timer         <= '0;
                hold_off      <= 1'b1;
                fetch_err_r   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.fetch_en && !hold_off) begin
                            mem_addr_r <= bus.pc;
                            mem_rd_r   <= 1'b1;
                            timer      <= '0;
                            state      <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.mem_valid) begin
                            instr_r       <= bus.mem_rdata;
                            instr_valid_r <= 1'b1;
                            inc_pc_r      <= 1'b1;
                            mem_rd_r      <= 1'b0;
                            state         <= ST_HOLD;
                        end else if (timer == TIMER_LAST) begin
                            mem_rd_r    <= 1'b0;
                            fetch_err_r <= 1'b1;
                            state       <= ST_ERROR;
                        end else begin
                            timer <= timer + 4'd1;
                        end
                    end
                    ST_HOLD: begin
                        if (bus.instr_ready) begin
                            instr_valid_r <= 1'b0;
                            state         <= ST_IDLE;
                        end
                    end
                    ST_ERROR: begin
                        state <= ST_ERROR;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_rd      = mem_rd_r;
    assign bus.instr       = instr_r;
    assign bus.opcode      = instr_r[INSTR_W-1 -: 4];
    assign bus.instr_valid = instr_valid_r;
    assign bus.inc_pc      = inc_pc_r;
    assign bus.fetch_err   = fetch_err_r;
endmodule
